// File: rtl/imem_loader.sv
// Boot loader: parses a header/payload/checksum byte stream into instruction memory, holding the CPU in reset until a good load.
// Latency: each memory write is issued one cycle after its byte is accepted; backpressure by dropping in_ready outside HDR/DATA/CSUM.
module imem_loader #(
    parameter int MAX_WORDS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       im_we,
    output logic [5:0] im_addr,
    output logic [7:0] im_wdata,
    output logic       cpu_rst,
    output logic       done,
    output logic       err,
    output logic [4:0] words_loaded
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t     state;
    logic [4:0] n_words;
    logic [5:0] byte_addr;
    logic [7:0] csum;
    logic [6:0] last_idx;
    logic       accept;
    logic       last_byte;

    assign in_ready  = RST && (state == S_HDR || state == S_DATA || state == S_CSUM);
    assign accept    = in_valid && in_ready;
    assign last_idx  = {n_words, 2'b00} - 7'd1;
    assign last_byte = ({1'b0, byte_addr} == last_idx);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= S_HDR;
            n_words      <= 5'd0;
            byte_addr    <= 6'd0;
            csum         <= 8'd0;
            im_we        <= 1'b0;
            im_addr      <= 6'd0;
            im_wdata     <= 8'd0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 5'd0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_HDR: begin
                    if (accept) begin
                        csum <= csum ^ in_data;
                        if (in_data == 8'd0) begin
                            n_words <= 5'd0;
                            state   <= S_CSUM;
                        end else if (in_data > MAX_N) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            n_words <= in_data[4:0];
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ in_data;
                        im_we    <= 1'b1;
                        im_addr  <= byte_addr;
                        im_wdata <= in_data;
                        // word counter moves together with the write of a word's final byte
                        if (byte_addr[1:0] == 2'b11 && words_loaded < n_words)
                            words_loaded <= words_loaded + 5'd1;
                        if (last_byte)
                            state <= S_CSUM;
                        else
                            byte_addr <= byte_addr + 6'd1;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // memory is left intact; the next load simply overwrites from address 0
                    if (start) begin
                        state        <= S_HDR;
                        n_words      <= 5'd0;
                        byte_addr    <= 6'd0;
                        csum         <= 8'd0;
                        words_loaded <= 5'd0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_rst      <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_HDR;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
